// File: rtl/keycode_event_ctrl_if.sv
// keycode_event_ctrl_if
// Event stream handshake between the keycode event sequencer (master) and
// the game/VGA logic that drains it (slave).
//   ev_valid  head of the event queue holds an event
//   ev_ready  consumer takes the head event this cycle
//   ev_code   keycode carried by the head event
//   ev_type   head event kind: 01 PRESS, 10 RELEASE, 11 REPEAT
interface keycode_event_ctrl_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic [1:0] ev_type;

    modport master (
        output ev_valid,
        output ev_code,
        output ev_type,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_code,
        input  ev_type,
        output ev_ready
    );
endinterface

// File: rtl/keycode_event_ctrl.sv
// keycode_event_ctrl
// Watches the keycode written by the NIOS to the PIO and turns changes into an
// ordered stream of PRESS / RELEASE / typematic REPEAT events. Events are held
// in a first-word-fall-through queue and drained over a valid/ready handshake.
// Ports:
//   clk           system clock, rising edge
//   reset_n       asynchronous, active-low reset
//   keycode_in    current keycode from the PIO, 0 means no key
//   ev            event stream (master side of keycode_event_ctrl_if)
//   fifo_count    number of queued events
//   overflow      sticky flag: an event was dropped because the queue was full
//   clr_overflow  synchronous clear of overflow
//   held_code     key currently reported as held, 0 when none
module keycode_event_ctrl #(
    parameter int DEPTH        = 8,
    parameter int DELAY_CYCLES = 25_000_000,
    parameter int RATE_CYCLES  = 2_500_000,
    parameter bit REPEAT_EN    = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [7:0]             keycode_in,
    keycode_event_ctrl_if.master   ev,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow,
    input  logic                   clr_overflow,
    output logic [7:0]             held_code
);

    localparam int AW         = $clog2(DEPTH);
    localparam int CW         = AW + 1;
    localparam int MAX_CYCLES = (DELAY_CYCLES > RATE_CYCLES) ? DELAY_CYCLES : RATE_CYCLES;
    localparam int TW         = $clog2(MAX_CYCLES);

    localparam logic [TW-1:0] DELAY_LAST = TW'(DELAY_CYCLES - 1);
    localparam logic [TW-1:0] RATE_LAST  = TW'(RATE_CYCLES - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    localparam logic [1:0] TYPE_PRESS   = 2'b01;
    localparam logic [1:0] TYPE_RELEASE = 2'b10;
    localparam logic [1:0] TYPE_REPEAT  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        EMIT_REL,
        EMIT_PRESS,
        HELD_DELAY,
        HELD_REPEAT
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    curCode_q, curCode_d;
    logic [7:0]    nxtCode_q, nxtCode_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          push;
    logic [9:0]    pushEntry;

    logic [9:0]    mem_q [DEPTH];
    logic [AW-1:0] rdPtr_q, wrPtr_q;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          fifoEmpty, fifoFull;
    logic          popEn, pushEn, dropEn;

    // Sequencer state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            curCode_q <= '0;
            nxtCode_q <= '0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            curCode_q <= curCode_d;
            nxtCode_q <= nxtCode_d;
            timer_q   <= timer_d;
        end
    end

    // Sequencer next state. Keycode changes are only looked at in IDLE and
    // the HELD states, so codes written while an EMIT is in flight are
    // skipped. A change wins over a REPEAT falling due in the same cycle.
    always_comb begin
        state_d   = state_q;
        curCode_d = curCode_q;
        nxtCode_d = nxtCode_q;
        timer_d   = timer_q;
        push      = 1'b0;
        pushEntry = '0;
        unique case (state_q)
            EMIT_REL: begin
                push      = 1'b1;
                pushEntry = {TYPE_RELEASE, curCode_q};
                if (nxtCode_q != 8'd0) begin
                    state_d = EMIT_PRESS;
                end else begin
                    curCode_d = '0;
                    state_d   = IDLE;
                end
            end
            EMIT_PRESS: begin
                push      = 1'b1;
                pushEntry = {TYPE_PRESS, nxtCode_q};
                curCode_d = nxtCode_q;
                timer_d   = '0;
                state_d   = HELD_DELAY;
            end
            default: begin
                if (keycode_in != curCode_q) begin
                    nxtCode_d = keycode_in;
                    state_d   = (curCode_q != 8'd0) ? EMIT_REL : EMIT_PRESS;
                end else if (REPEAT_EN && (state_q == HELD_DELAY)) begin
                    if (timer_q == DELAY_LAST) begin
                        push      = 1'b1;
                        pushEntry = {TYPE_REPEAT, curCode_q};
                        timer_d   = '0;
                        state_d   = HELD_REPEAT;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end else if (REPEAT_EN && (state_q == HELD_REPEAT)) begin
                    if (timer_q == RATE_LAST) begin
                        push      = 1'b1;
                        pushEntry = {TYPE_REPEAT, curCode_q};
                        timer_d   = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
        endcase
    end

    // A full queue still accepts a push when the head leaves in the same
    // cycle; a pop against an empty queue is ignored.
    assign fifoEmpty = (count_q == '0);
    assign fifoFull  = (count_q == FULL_COUNT);
    assign popEn     = !fifoEmpty && ev.ev_ready;
    assign pushEn    = push && (!fifoFull || popEn);
    assign dropEn    = push && fifoFull && !popEn;

    // Occupancy and sticky overflow; a drop beats a clear in the same cycle.
    always_comb begin
        count_d = count_q;
        if (pushEn && !popEn) begin
            count_d = count_q + CW'(1);
        end else if (!pushEn && popEn) begin
            count_d = count_q - CW'(1);
        end
        overflow_d = overflow_q;
        if (dropEn) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    // Queue pointers and flags; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdPtr_q    <= '0;
            wrPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (pushEn) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (popEn) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Queue storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            mem_q[wrPtr_q] <= pushEntry;
        end
    end

    assign ev.ev_valid = !fifoEmpty;
    assign ev.ev_code  = fifoEmpty ? 8'd0 : mem_q[rdPtr_q][7:0];
    assign ev.ev_type  = fifoEmpty ? 2'd0 : mem_q[rdPtr_q][9:8];
    assign fifo_count  = count_q;
    assign overflow    = overflow_q;
    assign held_code   = curCode_q;

endmodule

// File: tb/tb_keycode_event_ctrl.sv
// tb_keycode_event_ctrl
// Drives two copies of keycode_event_ctrl (repeats enabled and disabled) with
// directed and random keycode sequences and checks every cycle against an
// event-level model of what the sequencer and queue must produce.
module tb_keycode_event_ctrl;

    localparam int DEPTH = 4;
    localparam int DELAY = 10;
    localparam int RATE  = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] keycode = 8'd0;
    logic       evReady = 1'b1;
    logic       clrOverflow = 1'b0;
    logic [2:0] countA, countB;
    logic       ovfA, ovfB;
    logic [7:0] heldA, heldB;

    int checkCount = 0;
    int passCount = 0;
    int cyc = 0;
    int repB = 0;
    bit compareOn = 1'b0;

    logic [9:0] logEvQ[$];
    int         logCycQ[$];

    // Model state per instance: queue contents, pending emissions, held key and age.
    logic [9:0] mFifo [2][DEPTH];
    int         mCnt [2];
    bit         mOvf [2];
    logic [7:0] mCur [2];
    bit         mPendRel [2];
    bit         mPendPress [2];
    logic [7:0] mPendCode [2];
    int         mAge [2];
    bit         mFirst [2];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    keycode_event_ctrl_if busA ();
    keycode_event_ctrl_if busB ();
    assign busA.ev_ready = evReady;
    assign busB.ev_ready = evReady;

    keycode_event_ctrl #(.DEPTH(DEPTH), .DELAY_CYCLES(DELAY), .RATE_CYCLES(RATE), .REPEAT_EN(1'b1)) dutA (
        .clk(clk), .reset_n(reset_n), .keycode_in(keycode), .ev(busA),
        .fifo_count(countA), .overflow(ovfA), .clr_overflow(clrOverflow), .held_code(heldA)
    );

    keycode_event_ctrl #(.DEPTH(DEPTH), .DELAY_CYCLES(DELAY), .RATE_CYCLES(RATE), .REPEAT_EN(1'b0)) dutB (
        .clk(clk), .reset_n(reset_n), .keycode_in(keycode), .ev(busB),
        .fifo_count(countB), .overflow(ovfB), .clr_overflow(clrOverflow), .held_code(heldB)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            passCount++;
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] key);
        keycode = key;
    endtask

    task automatic modelReset();
        for (int m = 0; m < 2; m++) begin
            mCnt[m] = 0;
            mOvf[m] = 1'b0;
            mCur[m] = 8'd0;
            mPendRel[m] = 1'b0;
            mPendPress[m] = 1'b0;
            mPendCode[m] = 8'd0;
            mAge[m] = 0;
            mFirst[m] = 1'b1;
        end
    endtask

    // One clock edge of the model: emit any pending release/press, otherwise
    // notice a keycode change, otherwise age the held key and emit repeats.
    task automatic modelStep(input int m, input bit repEn);
        bit doPush;
        bit doPop;
        bit dropped;
        logic [9:0] evt;
        doPush = 1'b0;
        dropped = 1'b0;
        evt = 10'd0;
        doPop = (mCnt[m] != 0) && evReady;
        if (mPendRel[m]) begin
            doPush = 1'b1;
            evt = {2'b10, mCur[m]};
            mPendRel[m] = 1'b0;
            if (!mPendPress[m]) mCur[m] = 8'd0;
        end else if (mPendPress[m]) begin
            doPush = 1'b1;
            evt = {2'b01, mPendCode[m]};
            mCur[m] = mPendCode[m];
            mPendPress[m] = 1'b0;
            mAge[m] = 0;
            mFirst[m] = 1'b1;
        end else if (keycode != mCur[m]) begin
            mPendRel[m] = (mCur[m] != 8'd0);
            mPendPress[m] = (keycode != 8'd0);
            mPendCode[m] = keycode;
        end else if ((mCur[m] != 8'd0) && repEn) begin
            mAge[m]++;
            if (mAge[m] == (mFirst[m] ? DELAY : RATE)) begin
                doPush = 1'b1;
                evt = {2'b11, mCur[m]};
                mAge[m] = 0;
                mFirst[m] = 1'b0;
            end
        end
        if (doPop) begin
            for (int i = 0; i < DEPTH - 1; i++) mFifo[m][i] = mFifo[m][i+1];
            mCnt[m]--;
        end
        if (doPush) begin
            if (mCnt[m] < DEPTH) begin
                mFifo[m][mCnt[m]] = evt;
                mCnt[m]++;
            end else begin
                dropped = 1'b1;
            end
        end
        if (dropped) mOvf[m] = 1'b1;
        else if (clrOverflow) mOvf[m] = 1'b0;
    endtask

    // Model advances on the same edges as the DUTs and clears on reset.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) modelReset();
        else begin
            modelStep(0, 1'b1);
            modelStep(1, 1'b0);
        end
    end

    task automatic compareDut(input int m, input logic v, input logic [7:0] code, input logic [1:0] typ,
                              input logic [2:0] cnt, input logic ovf, input logic [7:0] held);
        logic expV;
        logic [9:0] head;
        expV = (mCnt[m] != 0);
        head = expV ? mFifo[m][0] : 10'd0;
        checkOutput($sformatf("dut%0d ev_valid", m), 32'(v), 32'(expV));
        checkOutput($sformatf("dut%0d ev_code", m), 32'(code), 32'(head[7:0]));
        checkOutput($sformatf("dut%0d ev_type", m), 32'(typ), 32'(head[9:8]));
        checkOutput($sformatf("dut%0d fifo_count", m), 32'(cnt), mCnt[m]);
        checkOutput($sformatf("dut%0d overflow", m), 32'(ovf), 32'(mOvf[m]));
        checkOutput($sformatf("dut%0d held_code", m), 32'(held), 32'(mCur[m]));
    endtask

    // Compare process: checks both DUTs against the model on every falling edge
    // and logs the events dutA hands over so directed checks can inspect them.
    always @(negedge clk) begin
        if (compareOn) begin
            compareDut(0, busA.ev_valid, busA.ev_code, busA.ev_type, countA, ovfA, heldA);
            compareDut(1, busB.ev_valid, busB.ev_code, busB.ev_type, countB, ovfB, heldB);
            if (reset_n && busA.ev_valid && evReady) begin
                logEvQ.push_back({busA.ev_type, busA.ev_code});
                logCycQ.push_back(cyc);
            end
            if (busB.ev_valid && (busB.ev_type == 2'b11)) repB++;
        end
    end

    function automatic logic [31:0] logEv(input int i);
        if (i < logEvQ.size()) return 32'(logEvQ[i]);
        return 32'hdead;
    endfunction

    function automatic int logCyc(input int i);
        if (i < logCycQ.size()) return logCycQ[i];
        return -1000;
    endfunction

    task automatic clearLog();
        logEvQ.delete();
        logCycQ.delete();
    endtask

    // Directed scenarios followed by a random phase.
    initial begin
        int hold;
        logic [7:0] key;
        $display("[TB] starting keycode_event_ctrl bench");
        waitCycles(1);
        compareOn = 1'b1;
        waitCycles(2);
        reset_n = 1'b1;

        // Idle after reset, then a first key press.
        waitCycles(20);
        checkOutput("t1 idle ev_valid", 32'(busA.ev_valid), 32'd0);
        checkOutput("t1 idle fifo_count", 32'(countA), 32'd0);
        clearLog();
        applyStimulus(8'h04);
        waitCycles(1);
        checkOutput("t1 valid one edge after change", 32'(busA.ev_valid), 32'd0);
        waitCycles(1);
        @(negedge clk);
        checkOutput("t1 valid two edges after change", 32'(busA.ev_valid), 32'd1);
        checkOutput("t1 press code", 32'(busA.ev_code), 32'h04);
        checkOutput("t1 press type", 32'(busA.ev_type), 32'h1);
        checkOutput("t1 held_code", 32'(heldA), 32'h04);

        // Hold the key: repeats after 10 cycles, then every 4; release stops them.
        waitCycles(22);
        applyStimulus(8'h00);
        waitCycles(25);
        checkOutput("t2 event count", logEvQ.size(), 32'd6);
        checkOutput("t2 first repeat", logEv(1), 32'h304);
        checkOutput("t2 first repeat delay", logCyc(1) - logCyc(0), 32'd10);
        checkOutput("t2 second repeat", logEv(2), 32'h304);
        checkOutput("t2 repeat interval", logCyc(2) - logCyc(1), 32'd4);
        checkOutput("t2 release last", logEv(5), 32'h204);

        // Direct key swap, then release.
        clearLog();
        applyStimulus(8'h04);
        waitCycles(5);
        applyStimulus(8'h05);
        waitCycles(5);
        applyStimulus(8'h00);
        waitCycles(5);
        checkOutput("t3 event count", logEvQ.size(), 32'd4);
        checkOutput("t3 press 04", logEv(0), 32'h104);
        checkOutput("t3 release 04", logEv(1), 32'h204);
        checkOutput("t3 press 05", logEv(2), 32'h105);
        checkOutput("t3 release/press adjacent", logCyc(2) - logCyc(1), 32'd1);
        checkOutput("t3 release 05", logEv(3), 32'h205);
        checkOutput("t3 held_code cleared", 32'(heldA), 32'd0);

        // Overflow: five events into a four-deep queue with the consumer stalled.
        evReady = 1'b0;
        clearLog();
        applyStimulus(8'h04); waitCycles(3);
        applyStimulus(8'h00); waitCycles(3);
        applyStimulus(8'h04); waitCycles(3);
        applyStimulus(8'h00); waitCycles(3);
        applyStimulus(8'h04); waitCycles(3);
        checkOutput("t4 fifo_count full", 32'(countA), 32'd4);
        checkOutput("t4 overflow set", 32'(ovfA), 32'd1);
        clrOverflow = 1'b1;
        waitCycles(1);
        clrOverflow = 1'b0;
        checkOutput("t4 overflow cleared", 32'(ovfA), 32'd0);
        evReady = 1'b1;
        waitCycles(4);
        checkOutput("t4 drained count", logEvQ.size(), 32'd4);
        checkOutput("t4 drain 0", logEv(0), 32'h104);
        checkOutput("t4 drain 1", logEv(1), 32'h204);
        checkOutput("t4 drain 2", logEv(2), 32'h104);
        checkOutput("t4 drain 3", logEv(3), 32'h204);
        applyStimulus(8'h00);
        waitCycles(5);

        // Push and pop together on a full queue.
        evReady = 1'b0;
        applyStimulus(8'h04); waitCycles(3);
        applyStimulus(8'h00); waitCycles(3);
        applyStimulus(8'h04); waitCycles(3);
        applyStimulus(8'h00); waitCycles(3);
        checkOutput("t5 fifo_count full", 32'(countA), 32'd4);
        clearLog();
        applyStimulus(8'h04);
        waitCycles(1);
        evReady = 1'b1;
        waitCycles(1);
        evReady = 1'b0;
        checkOutput("t5 fifo_count kept", 32'(countA), 32'd4);
        checkOutput("t5 no overflow", 32'(ovfA), 32'd0);
        evReady = 1'b1;
        waitCycles(5);
        checkOutput("t5 event count", logEvQ.size(), 32'd5);
        checkOutput("t5 popped head", logEv(0), 32'h104);
        checkOutput("t5 new tail", logEv(4), 32'h104);

        // Reset while repeating, then come out of reset with the key still down.
        waitCycles(8);
        reset_n = 1'b0;
        #1;
        checkOutput("t6 reset ev_valid", 32'(busA.ev_valid), 32'd0);
        checkOutput("t6 reset fifo_count", 32'(countA), 32'd0);
        checkOutput("t6 reset held_code", 32'(heldA), 32'd0);
        checkOutput("t6 reset overflow", 32'(ovfA), 32'd0);
        waitCycles(3);
        clearLog();
        reset_n = 1'b1;
        waitCycles(6);
        checkOutput("t6 single event", logEvQ.size(), 32'd1);
        checkOutput("t6 fresh press", logEv(0), 32'h104);
        applyStimulus(8'h00);
        waitCycles(5);
        checkOutput("t6 no repeats when disabled", repB, 32'd0);

        // Random keycodes, hold lengths, back-pressure and overflow clears.
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 4))
                0: key = 8'h00;
                1: key = 8'h04;
                2: key = 8'h05;
                3: key = 8'h1c;
                default: key = 8'($urandom);
            endcase
            applyStimulus(key);
            hold = ($urandom_range(0, 3) == 0) ? 1 : int'($urandom_range(2, 25));
            for (int h = 0; h < hold; h++) begin
                evReady = ($urandom_range(0, 3) != 0);
                clrOverflow = ($urandom_range(0, 7) == 0);
                waitCycles(1);
            end
            if ((n % 97) == 50) begin
                reset_n = 1'b0;
                waitCycles(2);
                reset_n = 1'b1;
            end
        end
        evReady = 1'b1;
        clrOverflow = 1'b0;
        applyStimulus(8'h00);
        waitCycles(10);
        checkOutput("end no repeats when disabled", repB, 32'd0);

        compareOn = 1'b0;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
